// File: rtl/fp_pipe_pkg.sv
// fp_pipe_pkg: shared defaults, tag-pipe entry type and one-hot to index helper
package fp_pipe_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int LATENCY_DEF = 13;
  localparam int TAG_MAX_W = 3;
  typedef struct packed {
    logic valid;
    logic [TAG_MAX_W-1:0] tag;
  } tag_entry_t;
  function automatic logic [TAG_MAX_W-1:0] onehot_to_idx(input logic [7:0] oh);
    logic [TAG_MAX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) idx = oh[i] ? (idx | TAG_MAX_W'(i)) : idx;
    return idx;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick (req, ptr in; one-hot grant, index out)
module rr_arbiter import fp_pipe_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W = 2,
  localparam int PTR_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [TAG_W-1:0]   idx
);
  logic found;
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int o = 0; o < NUM_REQ; o++) begin
      if (!found && req[(int'(ptr) + o) % NUM_REQ]) begin
        grant[(int'(ptr) + o) % NUM_REQ] = 1'b1;
        found = 1'b1;
      end
    end
    idx = TAG_W'(onehot_to_idx(8'(grant)));
  end
endmodule

// File: rtl/fp_pipe_arbiter.sv
// fp_pipe_arbiter: round-robin share of one pipelined FP operator (req_* in, op_* out, op_result* in, rsp_* out, in_flight/err status)
module fp_pipe_arbiter import fp_pipe_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = LATENCY_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TAG_W   = 2,
  parameter int CNT_W   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           op_a,
  output logic [DATA_W-1:0]           op_b,
  output logic                        op_data_available,
  input  logic [DATA_W-1:0]           op_result,
  input  logic                        op_result_available,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [CNT_W-1:0]            in_flight,
  output logic                        err
);
  localparam int PTR_W = $clog2(NUM_REQ);
  logic [PTR_W-1:0] ptr;
  logic [NUM_REQ-1:0] grant;
  logic [TAG_W-1:0] gidx;
  logic [CNT_W-1:0] drain_cnt;
  logic issue, retire, mismatch;
  logic [DATA_W-1:0] sel_a, sel_b;
  tag_entry_t pipe [LATENCY];
  tag_entry_t head;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) u_arb (
    .req(req_valid),
    .ptr(ptr),
    .grant(grant),
    .idx(gidx)
  );
  assign rsp_data = op_result;
  // head is the entry that has just left the last stage, lining up with the operator's output flag
  always_comb begin
    req_ready = rst_n ? grant : '0;
    issue = |req_ready;
    retire = pipe[LATENCY-1].valid;
    sel_a = req_a[int'(gidx)*DATA_W +: DATA_W];
    sel_b = req_b[int'(gidx)*DATA_W +: DATA_W];
    rsp_valid = (rst_n && op_result_available && head.valid) ? NUM_REQ'(1) << head.tag : '0;
    mismatch = (head.valid ^ op_result_available) && drain_cnt == '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a <= '0;
      op_b <= '0;
      op_data_available <= 1'b0;
      in_flight <= '0;
      err <= 1'b0;
      ptr <= '0;
      drain_cnt <= CNT_W'(LATENCY);
      head <= '0;
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      op_data_available <= issue;
      if (issue) begin
        op_a <= sel_a;
        op_b <= sel_b;
        ptr <= PTR_W'((int'(gidx) + 1) % NUM_REQ);
      end
      pipe[0] <= '{valid: issue, tag: TAG_MAX_W'(gidx)};
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
      head <= pipe[LATENCY-1];
      in_flight <= in_flight + CNT_W'(issue) - CNT_W'(retire);
      drain_cnt <= drain_cnt - CNT_W'(drain_cnt != '0);
      err <= err | mismatch;
    end
  end
endmodule
